hh_weight_stream_loader: RTL and testbench
==========================================

Name: hh_weight_stream_loader

Overview:
- Write-side feeder for the packed-pair weight memories (hidden-hidden gate memories: 8192 x 32-bit, two 16-bit signed weights per word).
- Accepts a valid/ready stream of 16-bit signed weights (host/UART/DMA side).
- Packs consecutive pairs into 32-bit words and drives the memory write port at sequential addresses.
- Reports completion, so the LSTM cell can begin reads only after a full reload.

Parameters:
- DATA_WIDTH, 16, width of one weight element.
- ADDR_WIDTH, 14, element address width; the word address is ADDR_WIDTH-1 bits wide.
- DEPTH, 8192, number of 32-bit words in the target memory. It must equal 2**(ADDR_WIDTH-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load at word address 0.
- abort  in  1  synchronous cancel. Returns to IDLE; no further writes.
- s_data  in  DATA_WIDTH  signed weight element.
- s_valid  in  1  element valid.
- s_last  in  1  final element of the load; sampled with s_valid.
- s_ready  out  1  loader can accept an element.
- write_enable  out  1  memory write strobe (registered).
- write_address  out  ADDR_WIDTH-1  word address (registered).
- write_data  out  2*DATA_WIDTH  packed pair (registered).
- busy  out  1  high while in LO or HI.
- done  out  1  one-cycle pulse when the load completes.
- word_count  out  ADDR_WIDTH  words written in the current or last load (0..DEPTH).

Behaviour:
- Reset (async, rst_n=0): state=IDLE. s_ready, write_enable, busy and done are 0. write_address, write_data and word_count are 0. The low-half holding register is 0.
- States: IDLE, LO, HI, FIN.
- IDLE:
  - s_ready=0.
  - start=1 causes LO next cycle, with the address counter=0 and word_count=0.
- LO:
  - s_ready=1, busy=1.
  - A handshake (s_valid & s_ready) captures s_data into lo_reg.
  - If s_last=0, next state is HI.
  - If s_last=1 (odd tail): next cycle issues a write with write_data={DATA_WIDTH zeros, s_data}, then FIN.
- HI:
  - s_ready=1, busy=1.
  - A handshake issues a write next cycle with write_data={s_data, lo_reg}. The first element is in [DATA_WIDTH-1:0]; the second is in [2*DATA_WIDTH-1:DATA_WIDTH].
  - If s_last=1, or the address being written equals DEPTH-1, next state is FIN. Otherwise next state is LO.
- Write timing:
  - write_enable is high for exactly one cycle per completed word.
  - Latency is 1 cycle from the accepting handshake.
  - write_address equals the counter value before increment. The counter and word_count increment on the same edge that asserts write_enable.
- Memory-full cutoff:
  - After the word at address DEPTH-1, no further elements are accepted.
  - s_ready is 0 from FIN onward.
  - There is no wrap to address 0 within a load.
- FIN:
  - Asserts done for one cycle.
  - write_enable is already low; the final write occurred in the preceding cycle.
  - Next state is IDLE. word_count holds its value until the next start.
- Edge cases:
  - start while busy or in FIN is ignored.
  - abort has priority over start and over any handshake in the same cycle. It causes IDLE, no write, and no done pulse. word_count keeps the words already written. A pending lo_reg is discarded.
  - s_valid=0 in LO or HI: the loader holds state with no timeout.
  - s_data is sampled only on a handshake.
  - rst_n asserted mid-load clears everything immediately; partial memory contents are left as written.
- Arithmetic: packing is bit concatenation only, with no sign extension of the zero pad. Element count is 2*word_count, or 2*word_count-1 after an odd tail.

Decomposition:
- Shared package (lstm_mem_pkg): DATA_WIDTH, ADDR_WIDTH, MEM_DEPTH constants and the loader state encoding (IDLE/LO/HI/FIN).
- One natural sub-module: pair_packer, holding lo_reg plus the registered write_data/write_enable stage. The FSM and counters stay in the top module.

Test Plan:
- Reset then start; stream 0x0001, 0x0002, 0x0003, 0x0004 with s_last on the 4th:
  - Writes addr0=0x00020001 and addr1=0x00040003.
  - done one cycle after the last write; word_count=2.
- Odd tail, stream 0xFFFF then 0x8000 with s_last:
  - addr0=0x8000FFFF.
  - Then 0x1234 with s_last in a new load gives addr0=0x00001234 and word_count=1.
- Full load of 16384 elements, no s_last:
  - The last write is to addr 8191.
  - s_ready drops to 0 after element 16384; extra s_valid is ignored. done pulses; word_count=8192.
- Backpressure gaps: random s_valid gaps produce identical write sequence and data to the gap-free case; no duplicate writes.
- abort after 3 elements:
  - One write (addr0), no done, lo_reg dropped.
  - A following start restarts at addr0.
- rst_n pulse low mid-HI: all outputs are 0 asynchronously. start issued in the same cycle as abort stays in IDLE.

Source files
------------

// File: rtl/lstm_mem_pkg.sv
// Shared constants and loader state encoding for the LSTM weight memories.
package lstm_mem_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 14;
    localparam int MEM_DEPTH  = 8192;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_FIN  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/hh_weight_stream_loader_pair_packer.sv
// Holds the low element of a pair and registers the memory write port; one-cycle latency.
// No backpressure of its own: every write strobe from the FSM becomes one write cycle.
module pair_packer #(
    parameter int DATA_WIDTH = 16,
    parameter int WADDR_W    = 13
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    lo_cap_i,
    input  logic                    pair_wr_i,
    input  logic                    tail_wr_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic [WADDR_W-1:0]      addr_i,
    output logic                    write_enable_o,
    output logic [WADDR_W-1:0]      write_address_o,
    output logic [2*DATA_WIDTH-1:0] write_data_o
);

    logic [DATA_WIDTH-1:0]   lo_q;
    logic                    we_q;
    logic [WADDR_W-1:0]      addr_q;
    logic [2*DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q <= '0;
        end else if (clear_i) begin
            lo_q <= '0;
        end else if (lo_cap_i) begin
            lo_q <= data_i;
        end
    end

    // First element of a pair sits in the low half; an odd tail is zero-padded, never sign-extended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= pair_wr_i || tail_wr_i;
            if (pair_wr_i) begin
                addr_q <= addr_i;
                data_q <= {data_i, lo_q};
            end else if (tail_wr_i) begin
                addr_q <= addr_i;
                data_q <= {{DATA_WIDTH{1'b0}}, data_i};
            end
        end
    end

    assign write_enable_o  = we_q;
    assign write_address_o = addr_q;
    assign write_data_o    = data_q;

endmodule

// File: rtl/hh_weight_stream_loader.sv
// Packs a stream of signed weights into 32-bit pairs at sequential addresses; write lands 1 cycle after handshake.
// s_ready is high only in LO/HI and drops after the last element or the final memory word; done follows the last write.
module hh_weight_stream_loader #(
    parameter int DATA_WIDTH = lstm_mem_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = lstm_mem_pkg::ADDR_WIDTH,
    parameter int DEPTH      = lstm_mem_pkg::MEM_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic                    write_enable,
    output logic [ADDR_WIDTH-2:0]   write_address,
    output logic [2*DATA_WIDTH-1:0] write_data,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   word_count
);

    import lstm_mem_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    ld_state_e             state_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] word_count_q;

    logic hs;
    logic lo_cap;
    logic tail_wr;
    logic pair_wr;

    // abort outranks any handshake in the same cycle, so it gates every capture and write.
    assign hs      = s_valid && ready_q && !abort;
    assign lo_cap  = hs && (state_q == ST_LO);
    assign tail_wr = lo_cap && s_last;
    assign pair_wr = hs && (state_q == ST_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            word_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
                ready_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            state_q      <= ST_LO;
                            ready_q      <= 1'b1;
                            busy_q       <= 1'b1;
                            word_count_q <= '0;
                        end
                    end
                    ST_LO: begin
                        if (lo_cap) begin
                            if (s_last) begin
                                state_q      <= ST_FIN;
                                ready_q      <= 1'b0;
                                busy_q       <= 1'b0;
                                word_count_q <= word_count_q + ONE;
                            end else begin
                                state_q <= ST_HI;
                            end
                        end
                    end
                    ST_HI: begin
                        if (pair_wr) begin
                            word_count_q <= word_count_q + ONE;
                            // Stop at the top word: a load never wraps back to address 0.
                            if (s_last || (word_count_q == LAST_WORD)) begin
                                state_q <= ST_FIN;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_LO;
                            end
                        end
                    end
                    ST_FIN: begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    pair_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .WADDR_W    (ADDR_WIDTH - 1)
    ) u_pair_packer (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear_i         (abort),
        .lo_cap_i        (lo_cap),
        .pair_wr_i       (pair_wr),
        .tail_wr_i       (tail_wr),
        .data_i          (s_data),
        .addr_i          (word_count_q[ADDR_WIDTH-2:0]),
        .write_enable_o  (write_enable),
        .write_address_o (write_address),
        .write_data_o    (write_data)
    );

    assign s_ready    = ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_hh_weight_stream_loader.sv
// Randomized bench for hh_weight_stream_loader against a pairing/packing reference model.
module tb_hh_weight_stream_loader;

    localparam int DEPTH = 8192;
    localparam int NELEM = 16400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] s_data = 16'h0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        write_enable;
    logic [12:0] write_address;
    logic [31:0] write_data;
    logic        busy;
    logic        done;
    logic [13:0] word_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_wr = 0;
    int last_wr_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int exp_wc = 0;

    logic [44:0] exp_q[$];
    logic [15:0] elem [0:NELEM-1];

    hh_weight_stream_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .busy          (busy),
        .done          (done),
        .word_count    (word_count)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write strobe must match the next word the model predicted.
    always @(negedge clk) begin
        if (write_enable) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got addr=%0d data=%08h, required no write", write_address, write_data);
            end else begin
                logic [44:0] w;
                w = exp_q.pop_front();
                if ({write_address, write_data} !== w) begin
                    n_err++;
                    $display("FAIL write_word: got addr=%0d data=%08h, required addr=%0d data=%08h",
                             write_address, write_data, w[44:32], w[31:0]);
                end
            end
            n_wr++;
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: consecutive elements pair up low-first; a final lone element is zero-padded only
    // when it carries s_last; the load never exceeds DEPTH words.
    task automatic build_model(input int n, input bit use_last);
        int words;
        words = 0;
        for (int i = 0; i < n && words < DEPTH; i += 2) begin
            logic [31:0] w;
            if (i + 1 < n) w = {elem[i+1], elem[i]};
            else if (use_last) w = {16'h0000, elem[i]};
            else break;
            exp_q.push_back({13'(words), w});
            words++;
        end
        exp_wc = words;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) elem[i] = 16'($urandom);
    endtask

    task automatic send_stream(input int n, input bit use_last, input int gap_pct,
                               input bit noise, input int budget, output int acc);
        int cycles;
        cycles = 0;
        acc = 0;
        while (acc < n && cycles < budget) begin
            @(negedge clk);
            cycles++;
            start = noise ? 1'($urandom_range(1)) : 1'b0;
            if (int'($urandom_range(99)) < gap_pct) begin
                s_valid = 1'b0;
                s_data  = 16'($urandom);
                s_last  = 1'($urandom_range(1));
            end else begin
                s_valid = 1'b1;
                s_data  = elem[acc];
                s_last  = use_last && (acc == n - 1);
                if (s_ready) acc++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        start   = 1'b0;
    endtask

    task automatic do_load(input int n, input bit use_last, input int gap_pct,
                           input bit noise, input int budget, output int acc);
        build_model(n, use_last);
        @(negedge clk);
        start = 1'b1;
        send_stream(n, use_last, gap_pct, noise, budget, acc);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({s_ready, write_enable, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got %b, required 0000", {s_ready, write_enable, busy, done});
        end
        n_cmp++;
        if ({write_address, write_data, word_count} !== 59'd0) begin
            n_err++;
            $display("FAIL reset_regs: got addr=%0d data=%08h wc=%0d, required all 0",
                     write_address, write_data, word_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ready: got %b, required 0", s_ready);
        end
    endtask

    task automatic test_basic();
        int acc, d0;
        elem[0] = 16'h0001; elem[1] = 16'h0002; elem[2] = 16'h0003; elem[3] = 16'h0004;
        d0 = done_cnt;
        do_load(4, 1'b1, 0, 1'b0, 100, acc);
        n_cmp++;
        if (acc !== 4) begin n_err++; $display("FAIL basic_accepted: got %0d, required 4", acc); end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL basic_writes_missing: got %0d left, required 0", exp_q.size()); end
        n_cmp++;
        if (done_cnt !== d0 + 1) begin n_err++; $display("FAIL basic_done_count: got %0d, required %0d", done_cnt - d0, 1); end
        n_cmp++;
        if (done_cyc !== last_wr_cyc + 1) begin n_err++; $display("FAIL basic_done_timing: got cycle %0d, required %0d", done_cyc, last_wr_cyc + 1); end
        n_cmp++;
        if (word_count !== 14'd2) begin n_err++; $display("FAIL basic_word_count: got %0d, required 2", word_count); end
    endtask

    task automatic test_odd_tail();
        int acc;
        elem[0] = 16'hFFFF; elem[1] = 16'h8000;
        do_load(2, 1'b1, 0, 1'b0, 100, acc);
        n_cmp++;
        if (exp_q.size() != 0 || word_count !== 14'd1) begin
            n_err++;
            $display("FAIL pair_ffff_8000: got %0d left wc=%0d, required 0 left wc=1", exp_q.size(), word_count);
        end
        elem[0] = 16'h1234;
        do_load(1, 1'b1, 0, 1'b0, 100, acc);
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL tail_writes_missing: got %0d left, required 0", exp_q.size()); end
        n_cmp++;
        if (word_count !== 14'd1) begin n_err++; $display("FAIL tail_word_count: got %0d, required 1", word_count); end
        n_cmp++;
        if (done_cyc !== last_wr_cyc + 1) begin n_err++; $display("FAIL tail_done_timing: got cycle %0d, required %0d", done_cyc, last_wr_cyc + 1); end
    endtask

    task automatic test_backpressure();
        for (int t = 0; t < 8; t++) begin
            int n, acc, d0;
            n = $urandom_range(1, 60);
            fill_random(n);
            d0 = done_cnt;
            do_load(n, 1'b1, 50, 1'b1, n * 20 + 100, acc);
            n_cmp++;
            if (acc !== n) begin n_err++; $display("FAIL bp_accepted[%0d]: got %0d, required %0d", t, acc, n); end
            n_cmp++;
            if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_writes_missing[%0d]: got %0d left, required 0", t, exp_q.size()); exp_q.delete(); end
            n_cmp++;
            if (word_count !== 14'(exp_wc) || done_cnt !== d0 + 1) begin
                n_err++;
                $display("FAIL bp_completion[%0d]: got wc=%0d done=%0d, required wc=%0d done=1", t, word_count, done_cnt - d0, exp_wc);
            end
        end
    endtask

    task automatic test_full();
        int acc, d0, w0;
        fill_random(NELEM);
        d0 = done_cnt;
        w0 = n_wr;
        do_load(2 * DEPTH + 4, 1'b0, 0, 1'b0, 2 * DEPTH + 40, acc);
        n_cmp++;
        if (acc !== 2 * DEPTH) begin n_err++; $display("FAIL full_accepted: got %0d, required %0d", acc, 2 * DEPTH); end
        n_cmp++;
        if (n_wr - w0 !== DEPTH || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL full_write_count: got %0d writes %0d left, required %0d writes 0 left", n_wr - w0, exp_q.size(), DEPTH);
            exp_q.delete();
        end
        n_cmp++;
        if (word_count !== 14'd8192) begin n_err++; $display("FAIL full_word_count: got %0d, required 8192", word_count); end
        n_cmp++;
        if (done_cnt !== d0 + 1 || done_cyc !== last_wr_cyc + 1) begin
            n_err++;
            $display("FAIL full_done: got count=%0d cycle=%0d, required count=1 cycle=%0d", done_cnt - d0, done_cyc, last_wr_cyc + 1);
        end
    endtask

    task automatic test_abort();
        int acc, d0;
        fill_random(3);
        build_model(3, 1'b0);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        send_stream(3, 1'b0, 0, 1'b0, 50, acc);
        abort   = 1'b1;
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_data  = 16'($urandom);
        @(negedge clk);
        abort   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        n_cmp++;
        if ({busy, s_ready} !== 2'b00) begin n_err++; $display("FAIL abort_idle: got busy/ready=%b, required 00", {busy, s_ready}); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL abort_first_word: got %0d left, required 0", exp_q.size()); exp_q.delete(); end
        n_cmp++;
        if (done_cnt !== d0 || word_count !== 14'd1) begin
            n_err++;
            $display("FAIL abort_no_done: got done=%0d wc=%0d, required done=0 wc=1", done_cnt - d0, word_count);
        end
        fill_random(2);
        do_load(2, 1'b1, 0, 1'b0, 50, acc);
        n_cmp++;
        if (exp_q.size() != 0 || word_count !== 14'd1 || done_cnt !== d0 + 1) begin
            n_err++;
            $display("FAIL abort_restart: got %0d left wc=%0d done=%0d, required 0 left wc=1 done=1", exp_q.size(), word_count, done_cnt - d0);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_load();
        int acc, w0;
        fill_random(3);
        build_model(3, 1'b0);
        @(negedge clk);
        start = 1'b1;
        send_stream(3, 1'b0, 0, 1'b0, 50, acc);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({s_ready, write_enable, busy, done} !== 4'b0000) begin
            n_err++;
            $display("FAIL midreset_flags: got %b, required 0000", {s_ready, write_enable, busy, done});
        end
        n_cmp++;
        if ({write_address, write_data, word_count} !== 59'd0) begin
            n_err++;
            $display("FAIL midreset_regs: got addr=%0d data=%08h wc=%0d, required all 0", write_address, write_data, word_count);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        w0 = n_wr;
        @(negedge clk);
        start   = 1'b1;
        abort   = 1'b1;
        s_valid = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        abort   = 1'b0;
        n_cmp++;
        if ({busy, s_ready} !== 2'b00) begin n_err++; $display("FAIL start_abort_idle: got busy/ready=%b, required 00", {busy, s_ready}); end
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        n_cmp++;
        if (n_wr !== w0 || word_count !== 14'd0) begin
            n_err++;
            $display("FAIL start_abort_quiet: got %0d writes wc=%0d, required 0 writes wc=0", n_wr - w0, word_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd_tail();
        test_backpressure();
        test_abort();
        test_reset_mid_load();
        test_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
